// File: rtl/lock_door_ctrl_if.sv
// Signal bundle between the code detector/door sensor side and the door latch controller.
// The master drives the detector pulses and sensor; the slave is the controller.
interface lock_door_ctrl_if;
  logic       unlock;
  logic       try_done;
  logic       door_closed;
  logic       latch_release;
  logic       alarm;
  logic       lockout;
  logic [2:0] state_out;

  modport master (
    output unlock,
    output try_done,
    output door_closed,
    input  latch_release,
    input  alarm,
    input  lockout,
    input  state_out
  );

  modport slave (
    input  unlock,
    input  try_done,
    input  door_closed,
    output latch_release,
    output alarm,
    output lockout,
    output state_out
  );
endinterface

// File: rtl/lock_door_ctrl.sv
// Door latch controller: turns the code detector's unlock pulse into a timed relay release
// and supervises the door sensor for ajar, forced-entry and repeated-failure lockout.
module lock_door_ctrl #(
  parameter int TW             = 16,
  parameter int RELEASE_CYCLES = 1000,
  parameter int AJAR_CYCLES    = 5000,
  parameter int LOCKOUT_CYCLES = 20000,
  parameter int MAX_TRIES      = 3
) (
  input  logic              clk,
  input  logic              reset,
  lock_door_ctrl_if.slave   bus
);

  localparam int TRW = (MAX_TRIES + 1 > 2) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [TW-1:0]  RELEASE_LOAD = TW'(RELEASE_CYCLES - 1);
  localparam logic [TW-1:0]  AJAR_LOAD    = TW'(AJAR_CYCLES - 1);
  localparam logic [TW-1:0]  LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]  TIMER_ONE    = TW'(1);
  localparam logic [TRW-1:0] TRIES_ZERO   = {TRW{1'b0}};
  localparam logic [TRW-1:0] TRIES_ONE    = TRW'(1);
  localparam logic [TRW-1:0] TRIES_LAST   = TRW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_RELEASED = 3'd1,
    ST_OPEN     = 3'd2,
    ST_AJAR     = 3'd3,
    ST_FORCED   = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [TRW-1:0] tries_q, tries_d;

  logic           timer_zero_s;
  logic [TW-1:0]  timer_dec_s;

  assign timer_zero_s = (timer_q == TIMER_ZERO);
  assign timer_dec_s  = timer_zero_s ? TIMER_ZERO : (timer_q - TIMER_ONE);

  // State, shared down-timer and failed-attempt counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOCKED;
      timer_q <= TIMER_ZERO;
      tries_q <= TRIES_ZERO;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
    end
  end

  // Next-state, timer and tries logic; every branch lists its priority order explicitly
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;

    case (state_q)
      ST_LOCKED: begin
        if (!bus.door_closed) begin
          state_d = ST_FORCED;
        end else if (bus.unlock) begin
          state_d = ST_RELEASED;
          timer_d = RELEASE_LOAD;
          tries_d = TRIES_ZERO;
        end else if (bus.try_done) begin
          if (tries_q == TRIES_LAST) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCKOUT_LOAD;
            tries_d = TRIES_ZERO;
          end else begin
            tries_d = tries_q + TRIES_ONE;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end

      ST_RELEASED: begin
        if (!bus.door_closed) begin
          state_d = ST_OPEN;
          timer_d = AJAR_LOAD;
        end else if (bus.unlock) begin
          timer_d = RELEASE_LOAD;
        end else if (timer_zero_s) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_dec_s;
        end
      end

      ST_OPEN: begin
        if (bus.door_closed) begin
          state_d = ST_LOCKED;
        end else if (timer_zero_s) begin
          state_d = ST_AJAR;
        end else begin
          timer_d = timer_dec_s;
        end
      end

      ST_AJAR: begin
        if (bus.door_closed) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_AJAR;
        end
      end

      // Only a valid code with the door back shut clears a forced entry
      ST_FORCED: begin
        if (bus.unlock && bus.door_closed) begin
          state_d = ST_LOCKED;
          tries_d = TRIES_ZERO;
        end else begin
          state_d = ST_FORCED;
        end
      end

      ST_LOCKOUT: begin
        tries_d = TRIES_ZERO;
        if (!bus.door_closed) begin
          state_d = ST_FORCED;
        end else if (timer_zero_s) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_dec_s;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  // Outputs depend on the registered state only, so reset clears them without a clock edge
  assign bus.latch_release = (state_q == ST_RELEASED);
  assign bus.alarm         = (state_q == ST_AJAR) || (state_q == ST_FORCED);
  assign bus.lockout       = (state_q == ST_LOCKOUT);
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_lock_door_ctrl.sv
// Scoreboard bench for lock_door_ctrl: each driven cycle queues the state expected after the
// next rising edge; a monitor pops and compares all outputs one time unit after that edge.
module tb_lock_door_ctrl;

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_RELEASED = 3'd1;
  localparam logic [2:0] S_OPEN     = 3'd2;
  localparam logic [2:0] S_AJAR     = 3'd3;
  localparam logic [2:0] S_FORCED   = 3'd4;
  localparam logic [2:0] S_LOCKOUT  = 3'd5;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [2:0] exp_q[$];

  lock_door_ctrl_if bus ();

  lock_door_ctrl #(
    .TW             (16),
    .RELEASE_CYCLES (4),
    .AJAR_CYCLES    (6),
    .LOCKOUT_CYCLES (8),
    .MAX_TRIES      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector {state_out, latch_release, alarm, lockout} for a given state
  function automatic logic [5:0] expect_vec(input logic [2:0] s);
    logic lr, al, lo;
    lr = (s == S_RELEASED);
    al = (s == S_AJAR) || (s == S_FORCED);
    lo = (s == S_LOCKOUT);
    return {s, lr, al, lo};
  endfunction

  function automatic logic [5:0] actual_vec();
    return {bus.state_out, bus.latch_release, bus.alarm, bus.lockout};
  endfunction

  // Monitor: compare the DUT against each queued expectation just after the edge
  initial begin
    logic [2:0] e;
    logic [5:0] a;
    logic [5:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual_vec();
        r = expect_vec(e);
        total = total + 1;
        if (a !== r) begin
          bad = bad + 1;
          $display("FAIL cycle_check t=%0t actual={st,lr,al,lo}=%b required=%b", $time, a, r);
        end
      end
    end
  end

  task automatic step(input logic u, input logic t, input logic d, input logic [2:0] exp_s);
    bus.unlock      = u;
    bus.try_done    = t;
    bus.door_closed = d;
    exp_q.push_back(exp_s);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_n(input int n, input logic [2:0] exp_s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, exp_s);
  endtask

  task automatic check_zero(input string name);
    logic [5:0] a;
    a = actual_vec();
    total = total + 1;
    if (a !== 6'b000000) begin
      bad = bad + 1;
      $display("FAIL %s actual={st,lr,al,lo}=%b required=000000", name, a);
    end
  endtask

  // Let the last queued expectation be checked, then assert reset between edges
  task automatic reset_mid(input string name);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero(name);
    bus.unlock      = 1'b0;
    bus.try_done    = 1'b0;
    bus.door_closed = 1'b1;
    @(posedge clk);
    #1;
    check_zero({name, "_held"});
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog bench did not complete");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.unlock      = 1'b0;
    bus.try_done    = 1'b0;
    bus.door_closed = 1'b1;
    #1;
    reset = 1'b1;
    #2;
    check_zero("reset_state");
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    // Release timeout: latch high for exactly 4 cycles
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    idle_n(3, S_RELEASED);
    idle_n(2, S_LOCKED);

    // Unlock reloads the release timer; try_done ignored while released
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    step(1'b0, 1'b1, 1'b1, S_RELEASED);
    step(1'b0, 1'b0, 1'b1, S_RELEASED);
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    idle_n(3, S_RELEASED);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Normal entry: door opens 2 cycles after unlock, closes after 3
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    step(1'b0, 1'b0, 1'b1, S_RELEASED);
    step(1'b0, 1'b0, 1'b0, S_OPEN);
    step(1'b0, 1'b0, 1'b0, S_OPEN);
    step(1'b0, 1'b0, 1'b0, S_OPEN);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Ajar: 6 cycles in OPEN then alarm; inputs ignored in AJAR; closing clears it
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    step(1'b0, 1'b0, 1'b0, S_OPEN);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, S_OPEN);
    step(1'b0, 1'b0, 1'b0, S_AJAR);
    step(1'b1, 1'b1, 1'b0, S_AJAR);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Lockout after three failed attempts, 8 cycles, unlock ignored
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKOUT);
    idle_n(3, S_LOCKOUT);
    step(1'b1, 1'b1, 1'b1, S_LOCKOUT);
    idle_n(3, S_LOCKOUT);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Tries were cleared by lockout; unlock beats try_done on the third attempt
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b1, 1'b1, 1'b1, S_RELEASED);
    idle_n(3, S_RELEASED);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Unlock cleared tries: two more are tolerated, the third locks out
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKOUT);
    // Door opening during lockout is forced entry
    step(1'b0, 1'b0, 1'b0, S_FORCED);
    step(1'b1, 1'b0, 1'b0, S_FORCED);
    step(1'b0, 1'b0, 1'b1, S_FORCED);
    step(1'b1, 1'b0, 1'b1, S_LOCKED);

    // Forced entry from LOCKED; exit clears tries
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b0, 1'b0, S_FORCED);
    step(1'b1, 1'b0, 1'b0, S_FORCED);
    step(1'b0, 1'b0, 1'b1, S_FORCED);
    step(1'b1, 1'b0, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    // Asynchronous reset mid-RELEASED
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    step(1'b0, 1'b0, 1'b1, S_RELEASED);
    reset_mid("reset_in_released");
    idle_n(1, S_LOCKED);

    // Asynchronous reset mid-AJAR
    step(1'b1, 1'b0, 1'b1, S_RELEASED);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, S_OPEN);
    step(1'b0, 1'b0, 1'b0, S_AJAR);
    reset_mid("reset_in_ajar");

    // Tries are zero after reset: two attempts stay locked
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b1, 1'b1, S_LOCKED);
    step(1'b0, 1'b0, 1'b1, S_LOCKED);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
